// File: rtl/serial_compare_unit_if.sv
// Start/ready/done handshake bundle between the sequential control FSM
// and the serial comparator.
interface serial_compare_unit_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             lt;
  logic             eq;

  // Control FSM side
  modport master (
    output start, signed_op, a, b,
    input  ready, done, lt, eq
  );

  // Comparator side
  modport slave (
    input  start, signed_op, a, b,
    output ready, done, lt, eq
  );
endinterface

// File: rtl/serial_compare_unit.sv
// Multi-cycle SLT/SLTU/equality comparator. Operands are scanned LSB-first,
// BITS_PER_CYCLE bits per clock. The most significant differing bit decides
// lt, because each later (higher) bit overrides the accumulated verdict.
// In signed mode only the sign bit flips the sense of the decision.
// WIDTH must be a multiple of BITS_PER_CYCLE.
module serial_compare_unit #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  serial_compare_unit_if.slave bus
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  // Operand copies shift right each RUN cycle so the current chunk is
  // always at bits [BITS_PER_CYCLE-1:0]; avoids a wide index mux.
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              signed_q;
  logic              lt_acc_q;
  logic              eq_acc_q;
  logic              ready_q;
  logic              done_q;
  logic              lt_q;
  logic              eq_q;

  logic              last_chunk;
  logic              lt_acc_d;
  logic              eq_acc_d;

  assign last_chunk = (cnt_q == CntW'(N - 1));

  // Fold the current chunk into the accumulators, lowest bit first.
  always_comb begin
    lt_acc_d = lt_acc_q;
    eq_acc_d = eq_acc_q;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (a_q[j] != b_q[j]) begin
        eq_acc_d = 1'b0;
        // Sign bit: a negative a (a=1, b=0) is the smaller operand.
        if (signed_q && last_chunk && (j == BITS_PER_CYCLE - 1)) begin
          lt_acc_d = a_q[j];
        end else begin
          lt_acc_d = b_q[j];
        end
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cnt_q    <= '0;
      lt_acc_q <= 1'b0;
      eq_acc_q <= 1'b1;
      signed_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            signed_q <= bus.signed_op;
            cnt_q    <= '0;
            lt_acc_q <= 1'b0;
            eq_acc_q <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          lt_acc_q <= lt_acc_d;
          eq_acc_q <= eq_acc_d;
          if (last_chunk) begin
            lt_q    <= lt_acc_d;
            eq_q    <= eq_acc_d;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.lt    = lt_q;
  assign bus.eq    = eq_q;

endmodule

// File: tb/tb_serial_compare_unit.sv
// Scoreboard bench for serial_compare_unit: one instance with 1 bit/cycle,
// one with 4 bits/cycle. Drivers push expected results; per-instance
// monitors pop and compare whenever done is seen.
module tb_serial_compare_unit;

  localparam int W = 64;

  typedef struct {
    logic   lt;
    logic   eq;
    longint due;
    string  name;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  exp_t   q1[$];
  exp_t   q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_compare_unit_if #(.WIDTH(W)) bus1 ();
  serial_compare_unit_if #(.WIDTH(W)) bus4 ();

  serial_compare_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  serial_compare_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_check(input string tag, input exp_t e, input logic lt, input logic eq,
                           input logic ready);
    chk({tag, " ", e.name, " lt"}, 64'(lt), 64'(e.lt));
    chk({tag, " ", e.name, " eq"}, 64'(eq), 64'(e.eq));
    chk({tag, " ", e.name, " done cycle"}, 64'(cyc), 64'(e.due));
    chk({tag, " ", e.name, " ready low in DONE"}, 64'(ready), 64'd0);
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut1 unexpected done at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        mon_check("dut1", e, bus1.lt, bus1.eq, bus1.ready);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut4 unexpected done at cycle %0d", cyc);
      end else begin
        e = q4.pop_front();
        mon_check("dut4", e, bus4.lt, bus4.eq, bus4.ready);
      end
    end
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus1.ready : bus4.ready;
  endfunction

  // Called and returns at posedge+#1. Waits for ready, issues one start.
  task automatic issue(input int sel, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic elt, input logic eeq, input bit push, input string name);
    int   guard = 0;
    int   n = (sel == 0) ? 64 : 16;
    exp_t e;
    while (rdy(sel) !== 1'b1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      chk({name, " ready timeout"}, 64'(rdy(sel)), 64'd1);
      return;
    end
    if (sel == 0) begin
      bus1.start = 1'b1; bus1.signed_op = s; bus1.a = a; bus1.b = b;
    end else begin
      bus4.start = 1'b1; bus4.signed_op = s; bus4.a = a; bus4.b = b;
    end
    if (push) begin
      e.lt = elt; e.eq = eeq; e.due = cyc + 1 + n; e.name = name;
      if (sel == 0) q1.push_back(e);
      else q4.push_back(e);
    end
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic drain(input int sel);
    int guard = 0;
    while (((sel == 0) ? q1.size() : q4.size()) != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) begin
      chk($sformatf("dut%0d drain timeout, pending", (sel == 0) ? 1 : 4),
          64'((sel == 0) ? q1.size() : q4.size()), 64'd0);
      q1.delete();
      q4.delete();
    end
  endtask

  task automatic model(input logic s, input logic [63:0] a, input logic [63:0] b,
                       output logic lt, output logic eq);
    eq = (a == b);
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    logic        rs, elt, eeq;
    int          guard;

    reset = 1'b1;
    bus1.start = 1'b0; bus1.signed_op = 1'b0; bus1.a = '0; bus1.b = '0;
    bus4.start = 1'b0; bus4.signed_op = 1'b0; bus4.a = '0; bus4.b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset ready", 64'(bus1.ready), 64'd1);
    chk("reset done", 64'(bus1.done), 64'd0);
    chk("reset lt", 64'(bus1.lt), 64'd0);
    chk("reset eq", 64'(bus1.eq), 64'd0);
    chk("reset ready b4", 64'(bus4.ready), 64'd1);

    // 1: unsigned small, then ready returns and result holds
    issue(0, 1'b0, 64'd5, 64'd7, 1'b1, 1'b0, 1, "t1 5<7");
    guard = 0;
    while (bus1.done !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("t1 done seen", 64'(bus1.done), 64'd1);
    @(posedge clk);
    #1;
    chk("t1 ready after done", 64'(bus1.ready), 64'd1);
    chk("t1 done one cycle", 64'(bus1.done), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("t1 lt held", 64'(bus1.lt), 64'd1);

    // 2: sign mode
    issue(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1, "t2 u -1 vs 1");
    issue(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1, "t2 s -1 vs 1");

    // 3: equality and MSB-only operands
    issue(0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1, "t3 u eq");
    issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1, "t3 s eq");
    issue(0, 1'b0, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 1, "t3 u msb vs 0");
    issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1'b0, 1, "t3 s msb vs 0");
    drain(0);

    // 4: start while busy is ignored
    issue(0, 1'b0, 64'd3, 64'd2, 1'b0, 1'b0, 1, "t4 3 vs 2");
    repeat (10) @(posedge clk);
    #1;
    bus1.start = 1'b1; bus1.a = 64'd0; bus1.b = 64'd9;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    drain(0);
    repeat (80) @(posedge clk);
    #1;
    chk("t4 lt held", 64'(bus1.lt), 64'd0);
    chk("t4 eq held", 64'(bus1.eq), 64'd0);

    // Leave lt=1 so the reset check below is meaningful
    issue(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0, 1, "t5 pre");
    drain(0);
    @(posedge clk);
    #1;

    // 5: reset in the middle of RUN aborts without a done pulse
    issue(0, 1'b0, 64'd5, 64'd7, 1'b1, 1'b0, 0, "t5 aborted");
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5 ready after reset", 64'(bus1.ready), 64'd1);
    chk("t5 lt after reset", 64'(bus1.lt), 64'd0);
    chk("t5 eq after reset", 64'(bus1.eq), 64'd0);
    chk("t5 done after reset", 64'(bus1.done), 64'd0);
    repeat (100) @(posedge clk);
    #1;
    issue(0, 1'b0, 64'd1, 64'd2, 1'b1, 1'b0, 1, "t5 1<2");
    drain(0);

    // 6: four bits per cycle
    issue(1, 1'b0, 64'h10, 64'h0F, 1'b0, 1'b0, 1, "t6 0x10 vs 0x0F");
    issue(1, 1'b1, 64'h0F, 64'h8000_0000_0000_0010, 1'b0, 1'b0, 1, "t6 s pos vs neg");
    issue(1, 1'b0, 64'h0F, 64'h8000_0000_0000_0010, 1'b1, 1'b0, 1, "t6 u small vs big");
    drain(1);

    // Random regression against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (64'd1 << $urandom_range(0, 63));
        2: rb = ra ^ 64'h8000_0000_0000_0000;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      model(rs, ra, rb, elt, eeq);
      issue(1, rs, ra, rb, elt, eeq, 1, "rand4");
    end
    drain(1);
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = ra ^ (64'd1 << $urandom_range(0, 63));
      if (i % 5 == 0) rb = ra;
      rs = 1'($urandom_range(0, 1));
      model(rs, ra, rb, elt, eeq);
      issue(0, rs, ra, rb, elt, eeq, 1, "rand1");
    end
    drain(0);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
